// File: rtl/kernel_buffer_controller.sv
// rtl/kernel_buffer_controller.sv - kernel buffer load/read sequencer
//
// Purpose:
//   LOAD streams W-bit weights in over a valid/ready handshake and writes them
//   round-robin across D banks: weight k goes to bank k mod D, address k div D.
//   READ sweeps a contiguous address range. All D banks are read in parallel.
//   The SRAM has one cycle of latency, so opValid trails each address by one cycle.
//
// Ports:
//   CLK, RSTn    clock (rising edge) and synchronous active-low reset
//   cfgNumWords  number of weights to load (0..D*2^A), sampled on loadStart
//   loadStart    begin LOAD (honoured in IDLE only; wins over readStart)
//   inData/inValid/inReady   weight stream
//   readBase/readLen         read sweep start and length, sampled on readStart
//   readStart    begin READ (honoured in IDLE only)
//   ioInputs     {ioSelect, ioWrite, bankSelect, data} to the buffer
//   address      buffer address
//   opValid      buffer output valid this cycle
//   busy         controller not idle
//   loadDone     pulse with the final write
//   readDone     pulse with the final opValid

module kernel_buffer_controller #(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int W     = 16,
    localparam int D    = 1 << depth
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic [A+depth:0]       cfgNumWords,
    input  logic                   loadStart,
    input  logic [W-1:0]           inData,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [A-1:0]           readBase,
    input  logic [A:0]             readLen,
    input  logic                   readStart,
    output logic [W+depth+1:0]     ioInputs,
    output logic [A-1:0]           address,
    output logic                   opValid,
    output logic                   busy,
    output logic                   loadDone,
    output logic                   readDone
);

    localparam int CW = A + depth + 1;
    localparam int IW = W + depth + 2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN} state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic [IW-1:0]     r_io;
    logic [A-1:0]      r_address;
    logic              r_op_valid;
    logic              r_busy;
    logic              r_load_done;
    logic              r_read_done;

    logic [CW-1:0]     r_num;
    logic [CW-1:0]     r_ld_cnt;
    logic [depth-1:0]  r_bank;
    logic [A-1:0]      r_wr_addr;
    logic [A:0]        r_rd_len;
    logic [A:0]        r_rd_cnt;

    // IO mode with no write strobe: bus stays owned by the controller between words
    logic [IW-1:0]     w_io_hold;
    logic              w_last_word;

    assign w_io_hold   = {1'b1, 1'b0, {(depth + W){1'b0}}};
    assign w_last_word = ((r_ld_cnt + CW'(1)) == r_num);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_io        <= '0;
            r_address   <= '0;
            r_op_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
            r_read_done <= 1'b0;
            r_num       <= '0;
            r_ld_cnt    <= '0;
            r_bank      <= '0;
            r_wr_addr   <= '0;
            r_rd_len    <= '0;
            r_rd_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_io        <= '0;
                    r_address   <= '0;
                    r_in_ready  <= 1'b0;
                    r_op_valid  <= 1'b0;
                    r_load_done <= 1'b0;
                    r_read_done <= 1'b0;
                    if (loadStart) begin
                        r_num     <= cfgNumWords;
                        r_ld_cnt  <= '0;
                        r_bank    <= '0;
                        r_wr_addr <= '0;
                        if (cfgNumWords == '0) begin
                            r_load_done <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_busy     <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_io       <= w_io_hold;
                        end
                    end else if (readStart) begin
                        if (readLen == '0) begin
                            r_read_done <= 1'b1;
                        end else begin
                            r_state   <= S_READ;
                            r_busy    <= 1'b1;
                            r_address <= readBase;
                            r_rd_len  <= readLen;
                            r_rd_cnt  <= (A+1)'(1);
                        end
                    end
                end

                S_LOAD: begin
                    if (!r_in_ready) begin
                        // final write and loadDone were shown this cycle
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_io        <= '0;
                        r_address   <= '0;
                        r_load_done <= 1'b0;
                    end else if (inValid) begin
                        r_io      <= {1'b1, 1'b1, r_bank, inData};
                        r_address <= r_wr_addr;
                        r_bank    <= r_bank + depth'(1);
                        if (r_bank == '1)
                            r_wr_addr <= r_wr_addr + A'(1);
                        r_ld_cnt  <= r_ld_cnt + CW'(1);
                        if (w_last_word) begin
                            r_in_ready  <= 1'b0;
                            r_load_done <= 1'b1;
                        end
                    end else begin
                        r_io <= w_io_hold;
                    end
                end

                S_READ: begin
                    // data for the address shown this cycle appears next cycle
                    r_op_valid <= 1'b1;
                    if (r_rd_cnt == r_rd_len) begin
                        r_state     <= S_DRAIN;
                        r_read_done <= 1'b1;
                    end else begin
                        r_address <= r_address + A'(1);
                        r_rd_cnt  <= r_rd_cnt + (A+1)'(1);
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_op_valid  <= 1'b0;
                    r_read_done <= 1'b0;
                    r_address   <= '0;
                end
            endcase
        end
    end

    assign inReady  = r_in_ready;
    assign ioInputs = r_io;
    assign address  = r_address;
    assign opValid  = r_op_valid;
    assign busy     = r_busy;
    assign loadDone = r_load_done;
    assign readDone = r_read_done;

endmodule

// File: tb/tb_kernel_buffer_controller.sv
// tb/tb_kernel_buffer_controller.sv - self-checking bench for kernel_buffer_controller

module tb_kernel_buffer_controller;

    localparam int DEPTH = 2;
    localparam int A     = 7;
    localparam int W     = 16;
    localparam int IW    = W + DEPTH + 2;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic [A+DEPTH:0]  cfgNumWords;
    logic              loadStart;
    logic [W-1:0]      inData;
    logic              inValid;
    logic              inReady;
    logic [A-1:0]      readBase;
    logic [A:0]        readLen;
    logic              readStart;
    logic [IW-1:0]     ioInputs;
    logic [A-1:0]      address;
    logic              opValid;
    logic              busy;
    logic              loadDone;
    logic              readDone;

    int total = 0;
    int bad   = 0;

    kernel_buffer_controller #(.depth(DEPTH), .A(A), .W(W)) dut (
        .CLK(CLK), .RSTn(RSTn), .cfgNumWords(cfgNumWords), .loadStart(loadStart),
        .inData(inData), .inValid(inValid), .inReady(inReady), .readBase(readBase),
        .readLen(readLen), .readStart(readStart), .ioInputs(ioInputs), .address(address),
        .opValid(opValid), .busy(busy), .loadDone(loadDone), .readDone(readDone)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string          name;
        logic           rstn;
        logic           ld;
        logic           rd;
        logic           iv;
        logic [9:0]     cfg;
        logic [6:0]     base;
        logic [7:0]     len;
        logic           e_rdy;
        logic [IW-1:0]  e_io;
        logic [6:0]     e_addr;
        logic           chk_addr;
        logic           e_op;
        logic           e_busy;
        logic           e_ld;
        logic           e_rd;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"},  32'(inReady), 32'd0);
        chk({tag, "_io"},   32'(ioInputs), 32'd0);
        chk({tag, "_op"},   32'(opValid), 32'd0);
        chk({tag, "_ldd"},  32'(loadDone), 32'd0);
        chk({tag, "_rdd"},  32'(readDone), 32'd0);
    endtask

    // Drives one load and checks every cycle against an independent bank/address model.
    task automatic do_load(input int n, input bit toggle, input bit both, input bit rd_mid,
                           input int abort_after);
        int  k;
        bit  hs;
        bit  done;
        loadStart   = 1'b1;
        cfgNumWords = 10'(n);
        readStart   = both;
        readBase    = 7'd0;
        readLen     = 8'd3;
        inValid     = 1'b0;
        step();
        loadStart = 1'b0;
        readStart = 1'b0;
        chk("ld_start_busy", 32'(busy), 32'd1);
        chk("ld_start_rdy",  32'(inReady), 32'd1);
        chk("ld_start_sel",  32'(ioInputs[IW-1:IW-2]), 32'd2);
        k    = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 4 * n + 8 && !done; cyc++) begin
            inValid   = toggle ? (cyc % 2 == 0) : 1'b1;
            inData    = 16'(k + 1);
            readStart = rd_mid && (cyc == 2);
            hs        = inValid;
            if (abort_after != 0 && k == abort_after) begin
                RSTn    = 1'b0;
                inValid = 1'b0;
                step();
                RSTn = 1'b1;
                chk_idle_outputs("abort");
                chk("abort_addr", 32'(address), 32'd0);
                return;
            end
            step();
            readStart = 1'b0;
            chk("ld_op", 32'(opValid), 32'd0);
            if (hs) begin
                k++;
                chk("ld_io",   32'(ioInputs), 32'({2'b11, 2'((k - 1) % 4), 16'(k)}));
                chk("ld_addr", 32'(address), 32'((k - 1) / 4));
                if (k == 5) begin
                    chk("w5_bank", 32'(ioInputs[W+1:W]), 32'd0);
                    chk("w5_addr", 32'(address), 32'd1);
                end
                if (k == 10) begin
                    chk("w10_bank", 32'(ioInputs[W+1:W]), 32'd1);
                    chk("w10_addr", 32'(address), 32'd2);
                end
                if (k == n) begin
                    chk("ld_done",      32'(loadDone), 32'd1);
                    chk("ld_last_rdy",  32'(inReady), 32'd0);
                    chk("ld_last_busy", 32'(busy), 32'd1);
                    done = 1'b1;
                end else begin
                    chk("ld_done_early", 32'(loadDone), 32'd0);
                    chk("ld_rdy",        32'(inReady), 32'd1);
                end
            end else begin
                chk("ld_gap_sel", 32'(ioInputs[IW-1:IW-2]), 32'd2);
                chk("ld_gap_ldd", 32'(loadDone), 32'd0);
            end
        end
        if (!done) chk("ld_timeout", 32'd0, 32'd1);
        inValid = 1'b0;
        step();
        chk_idle_outputs("ld_end");
        step();
        chk("ld_no_read", 32'(busy), 32'd0);
    endtask

    initial begin
        RSTn = 1'b0; loadStart = 1'b1; readStart = 1'b0; inValid = 1'b1;
        inData = 16'h0; cfgNumWords = 10'd5; readBase = 7'd0; readLen = 8'd0;

        //          name        rstn ld rd iv cfg    base    len  rdy io   addr   ca op bsy ldd rdd
        vecs[0]  = '{"rst0",    0,   1, 0, 1, 10'd5, 7'd0,   8'd0, 0, '0, 7'd0,   1, 0, 0, 0, 0};
        vecs[1]  = '{"rst1",    0,   1, 0, 1, 10'd5, 7'd0,   8'd0, 0, '0, 7'd0,   1, 0, 0, 0, 0};
        vecs[2]  = '{"rst2",    0,   1, 0, 1, 10'd5, 7'd0,   8'd0, 0, '0, 7'd0,   1, 0, 0, 0, 0};
        vecs[3]  = '{"idle",    1,   0, 0, 0, 10'd0, 7'd0,   8'd0, 0, '0, 7'd0,   1, 0, 0, 0, 0};
        vecs[4]  = '{"rd_a126", 1,   0, 1, 0, 10'd0, 7'd126, 8'd4, 0, '0, 7'd126, 1, 0, 1, 0, 0};
        vecs[5]  = '{"rd_a127", 1,   0, 1, 0, 10'd0, 7'd10,  8'd9, 0, '0, 7'd127, 1, 1, 1, 0, 0};
        vecs[6]  = '{"rd_a0",   1,   1, 0, 0, 10'd3, 7'd0,   8'd0, 0, '0, 7'd0,   1, 1, 1, 0, 0};
        vecs[7]  = '{"rd_a1",   1,   0, 0, 0, 10'd0, 7'd0,   8'd0, 0, '0, 7'd1,   1, 1, 1, 0, 0};
        vecs[8]  = '{"rd_drain",1,   0, 0, 0, 10'd0, 7'd0,   8'd0, 0, '0, 7'd0,   0, 1, 1, 0, 1};
        vecs[9]  = '{"rd_end",  1,   0, 0, 0, 10'd0, 7'd0,   8'd0, 0, '0, 7'd0,   0, 0, 0, 0, 0};
        vecs[10] = '{"rd_len0", 1,   0, 1, 0, 10'd0, 7'd5,   8'd0, 0, '0, 7'd0,   0, 0, 0, 0, 1};
        vecs[11] = '{"rd_len0b",1,   0, 0, 0, 10'd0, 7'd0,   8'd0, 0, '0, 7'd0,   0, 0, 0, 0, 0};
        vecs[12] = '{"ld_cfg0", 1,   1, 0, 1, 10'd0, 7'd0,   8'd0, 0, '0, 7'd0,   0, 0, 0, 1, 0};
        vecs[13] = '{"ld_cfg0b",1,   0, 0, 0, 10'd0, 7'd0,   8'd0, 0, '0, 7'd0,   0, 0, 0, 0, 0};

        foreach (vecs[i]) begin
            RSTn        = vecs[i].rstn;
            loadStart   = vecs[i].ld;
            readStart   = vecs[i].rd;
            inValid     = vecs[i].iv;
            cfgNumWords = vecs[i].cfg;
            readBase    = vecs[i].base;
            readLen     = vecs[i].len;
            step();
            chk({vecs[i].name, "_rdy"},  32'(inReady),  32'(vecs[i].e_rdy));
            chk({vecs[i].name, "_io"},   32'(ioInputs), 32'(vecs[i].e_io));
            if (vecs[i].chk_addr)
                chk({vecs[i].name, "_addr"}, 32'(address), 32'(vecs[i].e_addr));
            chk({vecs[i].name, "_op"},   32'(opValid),  32'(vecs[i].e_op));
            chk({vecs[i].name, "_busy"}, 32'(busy),     32'(vecs[i].e_busy));
            chk({vecs[i].name, "_ldd"},  32'(loadDone), 32'(vecs[i].e_ld));
            chk({vecs[i].name, "_rdd"},  32'(readDone), 32'(vecs[i].e_rd));
        end
        loadStart = 1'b0;
        readStart = 1'b0;
        inValid   = 1'b0;
        step();

        do_load(10, 1'b0, 1'b0, 1'b0, 0);   // continuous stream
        do_load(10, 1'b1, 1'b0, 1'b0, 0);   // valid toggling with gaps
        do_load(6,  1'b0, 1'b1, 1'b1, 0);   // both starts together, readStart mid-load
        do_load(8,  1'b0, 1'b0, 1'b0, 3);   // reset after 3 words
        do_load(4,  1'b1, 1'b0, 1'b0, 0);   // fresh load restarts at bank 0 addr 0

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
